axi_master_bridge: RTL and testbench

Single-outstanding AXI4 master that turns a simple request/response port from the core or cache into AXI transactions toward the memory-side slave (the simulation SRAM or the SoC crossbar). Reads are INCR bursts of 1–256 beats for line fills and uncached loads. Writes are single-beat. Read beats and write acknowledgements return on one response channel. The AXI ID is fixed, and responses are checked for protocol consistency.

---
 rtl/axi_master_bridge.sv | 184 ++++++++++++++++++
 tb/tb_axi_master_bridge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_bridge.sv
// Single-outstanding AXI4 master: turns a request/response port into INCR read bursts
// and single-beat writes, and flags responses that break the protocol.
module axi_master_bridge #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic        proto_err,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  input  logic [3:0]  rid,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [3:0]  awid,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic [3:0]  wid,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [63:0] r_wdata;
  logic [7:0]  r_wstrb;
  logic [7:0]  r_beat_cnt;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_proto_err;

  logic w_last_beat;
  logic w_r_hs;
  logic w_b_hs;
  logic w_aw_hs;
  logic w_w_hs;

  assign w_last_beat = (r_beat_cnt == r_len);
  assign w_r_hs      = (r_state == S_R) && rvalid && rsp_ready;
  assign w_b_hs      = (r_state == S_B) && bvalid && rsp_ready;
  assign w_aw_hs     = awvalid && awready;
  assign w_w_hs      = wvalid && wready;

  // Completion is governed by the beat count; rlast is only cross-checked against it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state     <= S_IDLE;
      r_addr      <= 32'd0;
      r_len       <= 8'd0;
      r_size      <= 3'd0;
      r_wdata     <= 64'd0;
      r_wstrb     <= 8'd0;
      r_beat_cnt  <= 8'd0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr     <= req_addr;
            r_len      <= req_len;
            r_size     <= req_size;
            r_wdata    <= req_wdata;
            r_wstrb    <= req_wstrb;
            r_beat_cnt <= 8'd0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_state    <= req_write ? S_WR : S_AR;
          end
        end
        S_AR: begin
          if (arready) r_state <= S_R;
        end
        S_R: begin
          if (w_r_hs) begin
            if ((rlast != w_last_beat) || (rid != AXI_ID)) r_proto_err <= 1'b1;
            if (w_last_beat) r_state <= S_IDLE;
            else r_beat_cnt <= r_beat_cnt + 8'd1;
          end
        end
        S_WR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs) r_w_done <= 1'b1;
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) r_state <= S_B;
        end
        S_B: begin
          if (w_b_hs) begin
            if (bid != AXI_ID) r_proto_err <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE) && !areset;
  assign proto_err = r_proto_err;

  assign araddr  = r_addr;
  assign arid    = AXI_ID;
  assign arlen   = r_len;
  assign arsize  = r_size;
  assign arvalid = (r_state == S_AR);
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = (r_state == S_R) && rsp_ready;

  assign awaddr  = r_addr;
  assign awid    = AXI_ID;
  assign awlen   = 8'd0;
  assign awsize  = r_size;
  assign awvalid = (r_state == S_WR) && !r_aw_done;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = AXI_ID;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = (r_state == S_WR) && !r_w_done;
  assign bready  = (r_state == S_B) && rsp_ready;

  // Response port is a zero-latency view of whichever AXI response channel is active.
  assign rsp_valid = ((r_state == S_R) && rvalid) || ((r_state == S_B) && bvalid);
  assign rsp_data  = (r_state == S_R) ? rdata : 64'd0;
  assign rsp_last  = (r_state == S_R) ? w_last_beat : 1'b1;
  assign rsp_write = (r_state == S_B);
  assign rsp_err   = ((r_state == S_R) && (rresp != 2'b00)) ||
                     ((r_state == S_B) && (bresp != 2'b00));

endmodule

// File: tb/tb_axi_master_bridge.sv
// Table-driven bench for axi_master_bridge: a scripted AXI slave per vector, with
// expected responses queued at request time and checked as they leave the bridge.
module tb_axi_master_bridge;

  logic        aclk = 1'b0;
  logic        areset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_write, rsp_err, proto_err;
  logic [63:0] rsp_data;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache;
  logic [7:0]  arlen, awlen, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [63:0] rdata, wdata;
  logic        wlast, wvalid, wready, bvalid, bready;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  resp;
    int          rlast_at;
    int          stall;
    int          d0;
    int          d1;
    int          abort;
    logic        bad_id;
    logic        proto;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        write;
    logic        err;
  } rsp_t;

  vec_t tbl[10];
  rsp_t q[$];

  axi_master_bridge dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_write(rsp_write), .rsp_err(rsp_err), .proto_err(proto_err),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arvalid(arvalid),
    .arready(arready), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awvalid(awvalid),
    .awready(awready), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard: every response accepted on the next rising edge must match the queue head.
  always @(negedge aclk) begin
    if (!areset && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp_unexpected: got a response, expected none at %0t", $time);
      end else begin
        rsp_t e;
        e = q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_last", 64'(rsp_last), 64'(e.last));
        chk("rsp_write", 64'(rsp_write), 64'(e.write));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  task automatic do_txn(input vec_t v);
    int n;
    int mx;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_len = v.len;
    req_size = v.size; req_wdata = v.data; req_wstrb = v.strb;
    if (v.write) q.push_back('{64'd0, 1'b1, 1'b1, (v.resp != 2'b00)});
    else for (int b = 0; b <= int'(v.len); b++)
      q.push_back('{v.data + 64'(b), (b == int'(v.len)), 1'b0, (v.resp != 2'b00)});
    step();
    req_valid = 1'b0;
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    if (!v.write) begin
      chk("arvalid", 64'(arvalid), 64'd1);
      chk("araddr", 64'(araddr), 64'(v.addr));
      chk("arlen", 64'(arlen), 64'(v.len));
      chk("arsize", 64'(arsize), 64'(v.size));
      chk("arburst", 64'(arburst), 64'd1);
      chk("arid", 64'(arid), 64'd0);
      for (int k = 0; k < v.d0; k++) begin
        step();
        chk("arvalid_hold", 64'(arvalid), 64'd1);
      end
      arready = 1'b1;
      step();
      arready = 1'b0;
      chk("arvalid_drop", 64'(arvalid), 64'd0);
      for (int b = 0; b <= int'(v.len); b++) begin
        rvalid = 1'b1; rdata = v.data + 64'(b); rlast = (b == v.rlast_at);
        rresp = v.resp; rid = v.bad_id ? 4'h1 : 4'h0;
        if (b == v.abort) begin
          areset = 1'b1;
          #1;
          chk("rst_rready", 64'(rready), 64'd0);
          chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
          chk("rst_arvalid", 64'(arvalid), 64'd0);
          q.delete();
          rvalid = 1'b0;
          step();
          areset = 1'b0;
          #1;
          chk("rst_req_ready", 64'(req_ready), 64'd1);
          chk("rst_proto_err", 64'(proto_err), 64'd0);
          return;
        end
        if (b == v.stall) begin
          rsp_ready = 1'b0;
          repeat (2) begin
            #1;
            chk("stall_rready", 64'(rready), 64'd0);
            chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            step();
          end
          rsp_ready = 1'b1;
        end
        #1;
        chk("rready", 64'(rready), 64'd1);
        step();
      end
      rvalid = 1'b0;
      rlast = 1'b0;
    end else begin
      chk("awvalid", 64'(awvalid), 64'd1);
      chk("wvalid", 64'(wvalid), 64'd1);
      chk("awaddr", 64'(awaddr), 64'(v.addr));
      chk("awlen", 64'(awlen), 64'd0);
      chk("awsize", 64'(awsize), 64'(v.size));
      chk("wdata", wdata, v.data);
      chk("wstrb", 64'(wstrb), 64'(v.strb));
      chk("wlast", 64'(wlast), 64'd1);
      mx = (v.d0 > v.d1) ? v.d0 : v.d1;
      for (int c = 0; c <= mx; c++) begin
        awready = (c == v.d0);
        wready = (c == v.d1);
        chk("awvalid_wr", 64'(awvalid), 64'(c <= v.d0));
        chk("wvalid_wr", 64'(wvalid), 64'(c <= v.d1));
        chk("bready_wr", 64'(bready), 64'd0);
        step();
      end
      awready = 1'b0;
      wready = 1'b0;
      chk("awvalid_b", 64'(awvalid), 64'd0);
      bvalid = 1'b1; bresp = v.resp; bid = v.bad_id ? 4'h2 : 4'h0;
      #1;
      chk("bready", 64'(bready), 64'd1);
      step();
      bvalid = 1'b0;
    end
    chk("req_ready_after", 64'(req_ready), 64'd1);
    chk("proto_err", 64'(proto_err), 64'(v.proto));
    chk("q_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b0, 32'h8000_0000, 8'd0,   3'd3, 64'h1122334455667788, 8'h00, 2'b00, 0,   -1, 0, 0, -1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h8000_0100, 8'd3,   3'd3, 64'hA000_0000_0000_0000, 8'h00, 2'b00, 3, 1, 0, 0, -1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'h8000_1000, 8'd0,   3'd3, 64'hDEADBEEF00000000, 8'hF0, 2'b00, 0,   -1, 3, 0, -1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 32'h8000_0200, 8'd1,   3'd3, 64'h0000_0000_0000_0055, 8'h00, 2'b10, 1, -1, 1, 0, -1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 32'h8000_0008, 8'd0,   3'd2, 64'h0000_0000_0000_1234, 8'h0F, 2'b11, 0, -1, 0, 2, -1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 32'h8000_4000, 8'd255, 3'd2, 64'h0000_0000_0000_7700, 8'h00, 2'b00, 255, -1, 2, 0, -1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 32'h8000_0300, 8'd3,   3'd3, 64'h0000_0000_0000_00E0, 8'h00, 2'b00, 1, -1, 0, 0, -1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 32'h8000_0400, 8'd2,   3'd3, 64'h0000_0000_0000_00F0, 8'h00, 2'b00, 2, -1, 0, 0, 1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 32'h8000_0000, 8'd0,   3'd3, 64'h1122334455667788, 8'h00, 2'b00, 0,   -1, 0, 0, -1, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 32'h8000_0010, 8'd0,   3'd3, 64'h0000_0000_0000_0001, 8'h01, 2'b00, 0, -1, 1, 1, -1, 1'b1, 1'b1};

    areset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_len = 8'd0;
    req_size = 3'd0; req_wdata = 64'd0; req_wstrb = 8'd0; rsp_ready = 1'b1;
    arready = 1'b0; rid = 4'd0; rdata = 64'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'b00; bvalid = 1'b0;
    repeat (3) step();
    chk("rst_arvalid0", 64'(arvalid), 64'd0);
    chk("rst_awvalid0", 64'(awvalid), 64'd0);
    chk("rst_wvalid0", 64'(wvalid), 64'd0);
    chk("rst_rready0", 64'(rready), 64'd0);
    chk("rst_bready0", 64'(bready), 64'd0);
    chk("rst_rsp_valid0", 64'(rsp_valid), 64'd0);
    chk("rst_proto_err0", 64'(proto_err), 64'd0);
    chk("rst_araddr0", 64'(araddr), 64'd0);
    areset = 1'b0;
    #1;
    chk("rst_req_ready0", 64'(req_ready), 64'd1);
    step();

    for (int i = 0; i < 10; i++) begin
      do_txn(tbl[i]);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
